// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: control-flow type
// encodings, saturating-counter constants and the branch-outcome rule.
// Imported by sat_counter_table and branch_predict_unit.
package bpu_pkg;

    // Conditional branch type (branchE); 3'b111 is reserved and means "none".
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    // Jump type (jumpE); 2'b11 is reserved and means "none".
    localparam logic [1:0] J_NONE  = 2'd0;
    localparam logic [1:0] J_JAL   = 2'd1;
    localparam logic [1:0] J_JALR  = 2'd2;

    // Counter reset value: weakly-not-taken, i.e. one below the MSB threshold.
    function automatic int unsigned ctr_init_val(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Smallest counter value that predicts taken (MSB set).
    function automatic int unsigned ctr_taken_thresh(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic is_jump(input logic [1:0] jmp);
        return (jmp == J_JAL) || (jmp == J_JALR);
    endfunction

    function automatic logic is_cond_br(input logic [2:0] br);
        return (br >= BR_BEQ) && (br <= BR_BGEU);
    endfunction

    // Resolved direction; a valid jump overrides any branch type.
    function automatic logic actual_taken(input logic [2:0] br,
                                          input logic [1:0] jmp,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        logic t;
        t = 1'b0;
        if (is_jump(jmp)) begin
            t = 1'b1;
        end else begin
            case (br)
                BR_BEQ:  t = zero;
                BR_BNE:  t = !zero;
                BR_BLT:  t = lt;
                BR_BGE:  t = !lt;
                BR_BLTU: t = ltu;
                BR_BGEU: t = !ltu;
                default: t = 1'b0;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Branch history table of CTR_W-bit saturating counters.
// Latency: combinational read of registered state; write lands on next clk edge.
// Backpressure: none, one read and one update accepted every cycle.
// Ports: clk, rst (async active-high, all entries -> weakly-not-taken);
//        i_rd_idx / o_rd_ctr read port; i_wr_en, i_wr_idx, i_wr_taken update port.
module sat_counter_table
    import bpu_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0] o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init_val(CTR_W));

    logic [CTR_W-1:0] r_ctr [DEPTH];
    logic [CTR_W-1:0] w_cur;

    assign w_cur    = r_ctr[i_wr_idx];
    // No bypass: a same-cycle update is seen by the reader one cycle later.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (i_wr_en) begin
            if (i_wr_taken && (w_cur != {CTR_W{1'b1}})) begin
                r_ctr[i_wr_idx] <= w_cur + CTR_W'(1);
            end else if (!i_wr_taken && (w_cur != {CTR_W{1'b0}})) begin
                r_ctr[i_wr_idx] <= w_cur - CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor (bimodal BHT + tagged BTB) with execute-side resolution.
// Latency: fetch prediction and execute redirect are combinational; training lands on next clk edge.
// Backpressure: none, one lookup and one resolve per cycle; bubbles flagged by validE.
// Ports: pcF -> predTakenF/predTargetF (fetch lookup); validE, branchE, jumpE, zeroE, ltE, ltuE,
//        pcE, targetE, jalrTargetE, predTakenE, predTargetE -> redirectE/redirectPCE (resolve);
//        brCount/missCount saturating perf counters; clk, rst (async active-high).
// Build option BPU_GSHARE_EN: XORs a global history register into the BHT index
//        and adds ghrF (out) / ghrE (in, ghrF piped alongside predTakenE).
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int PERF_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pcF,
    output logic              predTakenF,
    output logic [XLEN-1:0]   predTargetF,
    input  logic              validE,
    input  logic [2:0]        branchE,
    input  logic [1:0]        jumpE,
    input  logic              zeroE,
    input  logic              ltE,
    input  logic              ltuE,
    input  logic [XLEN-1:0]   pcE,
    input  logic [XLEN-1:0]   targetE,
    input  logic [XLEN-1:0]   jalrTargetE,
    input  logic              predTakenE,
    input  logic [XLEN-1:0]   predTargetE,
    output logic              redirectE,
    output logic [XLEN-1:0]   redirectPCE,
    output logic [PERF_W-1:0] brCount,
    output logic [PERF_W-1:0] missCount
`ifdef BPU_GSHARE_EN
    ,
    output logic [IDX_W-1:0]  ghrF,
    input  logic [IDX_W-1:0]  ghrE
`endif
);

    localparam int               DEPTH      = 1 << IDX_W;
    localparam int               TAG_W      = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_THRESH = CTR_W'(ctr_taken_thresh(CTR_W));

    // ---------------- index / tag split ----------------
    logic [IDX_W-1:0] w_idx_f, w_idx_e;
    logic [TAG_W-1:0] w_tag_f, w_tag_e;
    logic [IDX_W-1:0] w_bht_rd_idx, w_bht_wr_idx;

    assign w_idx_f = pcF[IDX_W+1:2];
    assign w_tag_f = pcF[XLEN-1:IDX_W+2];
    assign w_idx_e = pcE[IDX_W+1:2];
    assign w_tag_e = pcE[XLEN-1:IDX_W+2];

    // ---------------- execute resolution ----------------
    logic            w_jump, w_jalr, w_jal, w_cond, w_ctrl, w_train, w_taken;
    logic [XLEN-1:0] w_tgt_act, w_pce_plus4;

    assign w_jump      = is_jump(jumpE);
    assign w_jal       = (jumpE == J_JAL);
    assign w_jalr      = (jumpE == J_JALR);
    assign w_cond      = is_cond_br(branchE) && !w_jump;
    assign w_ctrl      = w_jump || w_cond;
    assign w_taken     = actual_taken(branchE, jumpE, zeroE, ltE, ltuE);
    assign w_tgt_act   = w_jalr ? jalrTargetE : targetE;
    assign w_pce_plus4 = pcE + XLEN'(4);
    // JALR targets are data-dependent, so only conditional branches and JAL train.
    assign w_train     = validE && (w_cond || w_jal);

    assign redirectE   = validE && ((w_taken != predTakenE) ||
                                    (w_taken && (predTargetE != w_tgt_act)));
    assign redirectPCE = (validE && w_taken) ? w_tgt_act : w_pce_plus4;

    // ---------------- global history (optional) ----------------
`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_train) begin
            r_ghr <= {r_ghr[IDX_W-2:0], w_taken};
        end
    end

    assign ghrF         = r_ghr;
    assign w_bht_rd_idx = w_idx_f ^ r_ghr;
    // Update with the history seen at lookup time, not the current one.
    assign w_bht_wr_idx = w_idx_e ^ ghrE;
`else
    assign w_bht_rd_idx = w_idx_f;
    assign w_bht_wr_idx = w_idx_e;
`endif

    // ---------------- BHT ----------------
    logic [CTR_W-1:0] w_ctr_f;

    sat_counter_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_bht_rd_idx),
        .o_rd_ctr   (w_ctr_f),
        .i_wr_en    (w_train),
        .i_wr_idx   (w_bht_wr_idx),
        .i_wr_taken (w_taken)
    );

    // ---------------- BTB ----------------
    logic             r_btb_vld [DEPTH];
    logic [TAG_W-1:0] r_btb_tag [DEPTH];
    logic [XLEN-1:0]  r_btb_tgt [DEPTH];
    logic             w_btb_we, w_hit_f;

    // Not-taken outcomes leave the entry alone so a loop exit keeps its target.
    assign w_btb_we = w_train && w_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_btb_vld[i] <= 1'b0;
            end
        end else if (w_btb_we) begin
            r_btb_vld[w_idx_e] <= 1'b1;
        end
    end

    // Payload needs no reset: the cleared valid bit hides it.
    always_ff @(posedge clk) begin
        if (!rst && w_btb_we) begin
            r_btb_tag[w_idx_e] <= w_tag_e;
            r_btb_tgt[w_idx_e] <= w_tgt_act;
        end
    end

    assign w_hit_f     = r_btb_vld[w_idx_f] && (r_btb_tag[w_idx_f] == w_tag_f);
    assign predTakenF  = w_hit_f && (w_ctr_f >= CTR_THRESH);
    assign predTargetF = predTakenF ? r_btb_tgt[w_idx_f] : (pcF + XLEN'(4));

    // ---------------- performance counters ----------------
    logic [PERF_W-1:0] r_br_cnt, r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (validE && w_ctrl && (r_br_cnt != {PERF_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + PERF_W'(1);
            end
            if (redirectE && (r_miss_cnt != {PERF_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + PERF_W'(1);
            end
        end
    end

    assign brCount   = r_br_cnt;
    assign missCount = r_miss_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed sequences, a vector table
// for resolution rules, perf-counter saturation, mid-operation reset, and a
// randomized run against a table-level reference model.
module tb_branch_predict_unit;

    localparam int PW = 8;            // narrow perf counters so saturation is reachable
    localparam int PMAX = (1 << PW) - 1;

    logic          clk, rst;
    logic [31:0]   pcF, predTargetF, pcE, targetE, jalrTargetE, predTargetE, redirectPCE;
    logic          predTakenF, validE, zeroE, ltE, ltuE, predTakenE, redirectE;
    logic [2:0]    branchE;
    logic [1:0]    jumpE;
    logic [PW-1:0] brCount, missCount;
`ifdef BPU_GSHARE_EN
    logic [3:0]    ghrF, ghrE;
`endif

    branch_predict_unit #(.XLEN(32), .IDX_W(4), .CTR_W(2), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .predTargetF(predTargetF),
        .validE(validE), .branchE(branchE), .jumpE(jumpE), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
        .pcE(pcE), .targetE(targetE), .jalrTargetE(jalrTargetE), .predTakenE(predTakenE),
        .predTargetE(predTargetE), .redirectE(redirectE), .redirectPCE(redirectPCE),
        .brCount(brCount), .missCount(missCount)
`ifdef BPU_GSHARE_EN
        , .ghrF(ghrF), .ghrE(ghrE)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_br = 0;
    int exp_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] pc,
                             input logic et, input logic [31:0] etgt);
        pcF = pc;
        #1;
        chk({name, ".predTakenF"}, {31'd0, predTakenF}, {31'd0, et});
        chk({name, ".predTargetF"}, predTargetF, etgt);
    endtask

    // Drive one execute slot, check the combinational resolution, clock it,
    // then check the perf counters against the bench's own tally.
    task automatic exec(input string name, input logic v, input logic [2:0] br,
                        input logic [1:0] j, input logic z, input logic lt, input logic ltu,
                        input logic pt, input logic [31:0] ptgt, input logic [31:0] pce,
                        input logic [31:0] tgt, input logic [31:0] jt,
                        input logic er, input logic [31:0] epc);
        validE = v; branchE = br; jumpE = j; zeroE = z; ltE = lt; ltuE = ltu;
        predTakenE = pt; predTargetE = ptgt; pcE = pce; targetE = tgt; jalrTargetE = jt;
        #1;
        chk({name, ".redirectE"}, {31'd0, redirectE}, {31'd0, er});
        chk({name, ".redirectPCE"}, redirectPCE, epc);
        if (v && ((br >= 3'd1 && br <= 3'd6) || j == 2'd1 || j == 2'd2) && exp_br < PMAX) exp_br++;
        if (er && exp_miss < PMAX) exp_miss++;
        @(posedge clk); #1;
        validE = 1'b0;
        chk({name, ".brCount"}, 32'(brCount), exp_br);
        chk({name, ".missCount"}, 32'(missCount), exp_miss);
    endtask

    // ---------------- vector table for resolution rules ----------------
    typedef struct {
        logic v; logic [2:0] br; logic [1:0] j; logic z, lt, ltu, pt;
        logic [31:0] ptgt; logic er; logic [31:0] epc;
    } vec_t;
    localparam int NV = 15;
    vec_t vecs[NV];

    // ---------------- reference model ----------------
    int          m_ctr [16];
    bit          m_vld [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_br, m_miss;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1; m_vld[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
        end
        m_br = 0; m_miss = 0;
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i = (pc / 4) % 16;
        t = m_vld[i] && (m_tag[i] == pc / 64) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + (32'($urandom_range(0, 3)) * 64) + (32'($urandom_range(0, 15)) * 4);
    endfunction

    logic        r_t, r_taken, r_redir, r_isjump, r_train;
    logic [31:0] r_tg, r_pf, r_pe, r_act_tgt, r_rpc;
    int          r_idx;

    initial begin
        clk = 0; rst = 1;
        pcF = 32'h40; validE = 0; branchE = 0; jumpE = 0; zeroE = 0; ltE = 0; ltuE = 0;
        pcE = 0; targetE = 0; jalrTargetE = 0; predTakenE = 0; predTargetE = 0;
`ifdef BPU_GSHARE_EN
        ghrE = '0;
`endif
        #2;
        // Reset state (asynchronous: visible before any clock edge).
        fetch_chk("reset", 32'h40, 1'b0, 32'h44);
        chk("reset.brCount", 32'(brCount), 0);
        chk("reset.missCount", 32'(missCount), 0);
        chk("reset.redirectE", {31'd0, redirectE}, 0);
        @(posedge clk); #1;
        rst = 0;

        // BEQ trained twice at 0x40; same-cycle fetch sees the old table.
        fetch_chk("same_cycle", 32'h40, 1'b0, 32'h44);
        exec("beq1", 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 1, 32'h80);
        fetch_chk("after_beq1", 32'h40, 1'b1, 32'h80);
        exec("beq2", 1, 3'd1, 2'd0, 1, 0, 0, 1, 32'h80, 32'h40, 32'h80, 0, 0, 32'h80);
        // BNE not taken, predicted taken: counter 11 -> 10 -> 01 -> 00 -> 00.
        exec("bne1", 1, 3'd2, 2'd0, 1, 0, 0, 1, 32'h80, 32'h40, 32'h80, 0, 1, 32'h44);
        fetch_chk("ctr_10", 32'h40, 1'b1, 32'h80);
        exec("bne2", 1, 3'd2, 2'd0, 1, 0, 0, 1, 32'h80, 32'h40, 32'h80, 0, 1, 32'h44);
        fetch_chk("ctr_01", 32'h40, 1'b0, 32'h44);
        exec("bne3", 1, 3'd2, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 0, 32'h44);
        exec("bne4", 1, 3'd2, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 0, 32'h44);
        // One taken from 00 must give 01 (still not taken), two give 10.
        exec("beq_up1", 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 1, 32'h80);
        fetch_chk("no_wrap_low", 32'h40, 1'b0, 32'h44);
        exec("beq_up2", 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 1, 32'h80);
        fetch_chk("ctr_back_10", 32'h40, 1'b1, 32'h80);
        // JALR redirects but leaves both BHT and BTB alone.
        exec("jalr", 1, 3'd0, 2'd2, 0, 0, 0, 0, 32'h44, 32'h40, 32'h80, 32'h1234, 1, 32'h1234);
        fetch_chk("jalr_no_btb", 32'h40, 1'b1, 32'h80);
        exec("bne5", 1, 3'd2, 2'd0, 1, 0, 0, 1, 32'h80, 32'h40, 32'h80, 0, 1, 32'h44);
        fetch_chk("jalr_no_ctr", 32'h40, 1'b0, 32'h44);
        // Bubble holding a taken BEQ: no redirect, no training, no count.
        exec("bubble", 0, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 0, 32'h44);
        fetch_chk("bubble_no_train", 32'h40, 1'b0, 32'h44);
        // Upper saturation: 01 -> 10 -> 11 -> 11 -> 11, then one decrement stays taken.
        for (int k = 0; k < 4; k++)
            exec("beq_sat", 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 1, 32'h80);
        exec("bne_sat", 1, 3'd2, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 0, 32'h44);
        fetch_chk("no_wrap_high", 32'h40, 1'b1, 32'h80);

        // Resolution vectors at pcE=0x104, targetE=0x300, jalrTargetE=0x500.
        vecs[0]  = '{1'b1, 3'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h300}; // BLT taken
        vecs[1]  = '{1'b1, 3'd5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h108}; // BLTU not
        vecs[2]  = '{1'b1, 3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h108}; // BGE not
        vecs[3]  = '{1'b1, 3'd6, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h300}; // BGEU taken
        vecs[4]  = '{1'b1, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h300}; // BGE ok
        vecs[5]  = '{1'b1, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2fc, 1'b1, 32'h300}; // wrong tgt
        vecs[6]  = '{1'b1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h300}; // BNE taken
        vecs[7]  = '{1'b1, 3'd7, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h108}; // reserved
        vecs[8]  = '{1'b1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h300}; // JAL ok
        vecs[9]  = '{1'b1, 3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 32'h300}; // JAL wins
        vecs[10] = '{1'b1, 3'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h500}; // JALR wins
        vecs[11] = '{1'b1, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b0, 32'h108}; // rsvd jump
        vecs[12] = '{1'b0, 3'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h108}; // bubble
        vecs[13] = '{1'b1, 3'd5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h300}; // BLTU ok
        vecs[14] = '{1'b1, 3'd6, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h108}; // BGEU not
        for (int k = 0; k < NV; k++)
            exec($sformatf("vec%0d", k), vecs[k].v, vecs[k].br, vecs[k].j, vecs[k].z, vecs[k].lt,
                 vecs[k].ltu, vecs[k].pt, vecs[k].ptgt, 32'h104, 32'h300, 32'h500,
                 vecs[k].er, vecs[k].epc);

        // Drive both perf counters past all-ones; they must stick there.
        for (int k = 0; k < PMAX + 5; k++)
            exec("perf_sat", 1, 3'd0, 2'd2, 0, 0, 0, 0, 32'h108, 32'h104, 32'h300, 32'h500, 1, 32'h500);
        chk("perf_sat.miss_allones", 32'(missCount), PMAX);

        // Reset while a taken BEQ at 0x40 is waiting for its edge.
        validE = 1; branchE = 3'd1; jumpE = 2'd0; zeroE = 1; pcE = 32'h40; targetE = 32'h80;
        predTakenE = 0; pcF = 32'h40;
        #1; rst = 1; #1;
        chk("midrst.brCount", 32'(brCount), 0);
        chk("midrst.missCount", 32'(missCount), 0);
        chk("midrst.predTakenF", {31'd0, predTakenF}, 0);
        @(posedge clk); #1;
        validE = 0; rst = 0;
        exp_br = 0; exp_miss = 0;
        fetch_chk("midrst_after", 32'h40, 1'b0, 32'h44);
        fetch_chk("midrst_after2", 32'h104, 1'b0, 32'h108);
        // One taken from weakly-not-taken must predict taken.
        exec("midrst_train", 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'h44, 32'h40, 32'h80, 0, 1, 32'h80);
        fetch_chk("midrst_init01", 32'h40, 1'b1, 32'h80);

        // ---------------- randomized run against the model ----------------
        rst = 1; #1; rst = 0;
        model_reset();
        for (int it = 0; it < 500; it++) begin
            r_pf = rand_pc();
            pcF = r_pf;
            model_pred(r_pf, r_t, r_tg);

            r_pe = rand_pc();
            validE = ($urandom_range(0, 7) != 0);
            branchE = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: jumpE = 2'd1;
                1: jumpE = 2'd2;
                2: jumpE = 2'd3;
                default: jumpE = 2'd0;
            endcase
            zeroE = 1'($urandom); ltE = 1'($urandom); ltuE = 1'($urandom);
            pcE = r_pe;
            targetE = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
            jalrTargetE = $urandom & 32'hffff_fffe;
            if ($urandom_range(0, 1) == 0) begin
                model_pred(r_pe, predTakenE, predTargetE);
            end else begin
                predTakenE = 1'($urandom);
                predTargetE = ($urandom_range(0, 1) == 0) ? targetE : $urandom;
            end

            // Spec-level outcome.
            r_isjump = (jumpE == 2'd1) || (jumpE == 2'd2);
            if (r_isjump) r_taken = 1;
            else case (branchE)
                3'd1: r_taken = zeroE;
                3'd2: r_taken = !zeroE;
                3'd3: r_taken = ltE;
                3'd4: r_taken = !ltE;
                3'd5: r_taken = ltuE;
                3'd6: r_taken = !ltuE;
                default: r_taken = 0;
            endcase
            r_act_tgt = (jumpE == 2'd2) ? jalrTargetE : targetE;
            r_redir = validE && ((r_taken != predTakenE) || (r_taken && predTargetE != r_act_tgt));
            r_rpc = (validE && r_taken) ? r_act_tgt : r_pe + 32'd4;

            #1;
            chk("rnd.predTakenF", {31'd0, predTakenF}, {31'd0, r_t});
            chk("rnd.predTargetF", predTargetF, r_tg);
            chk("rnd.redirectE", {31'd0, redirectE}, {31'd0, r_redir});
            chk("rnd.redirectPCE", redirectPCE, r_rpc);
            chk("rnd.brCount", 32'(brCount), m_br);
            chk("rnd.missCount", 32'(missCount), m_miss);

            // Model update for this edge.
            if (validE && (r_isjump || (branchE >= 3'd1 && branchE <= 3'd6)) && m_br < PMAX) m_br++;
            if (r_redir && m_miss < PMAX) m_miss++;
            r_train = validE && ((jumpE == 2'd1) || (!r_isjump && branchE >= 3'd1 && branchE <= 3'd6));
            if (r_train) begin
                r_idx = (r_pe / 4) % 16;
                if (r_taken) begin
                    if (m_ctr[r_idx] < 3) m_ctr[r_idx]++;
                    m_vld[r_idx] = 1;
                    m_tag[r_idx] = r_pe / 64;
                    m_tgt[r_idx] = r_act_tgt;
                end else if (m_ctr[r_idx] > 0) begin
                    m_ctr[r_idx]--;
                end
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's combinational branch/jump select.
- Adds a PC-indexed branch history table (BHT) of saturating counters, a tagged branch target buffer (BTB), and full RV32I compare-branch resolution (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR).
- Fetch stage queries it for a predicted next PC. Execute stage resolves the real outcome, trains the tables, and raises a redirect/flush on misprediction.
- Also keeps saturating branch/mispredict performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_W, 4, BHT/BTB index bits (2**IDX_W entries, index = pc[IDX_W+1:2]).
- CTR_W, 2, saturating counter width; predict taken when MSB=1.
- PERF_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcF  in  XLEN  fetch PC.
- predTakenF  out  1  fetch prediction: taken.
- predTargetF  out  XLEN  predicted target (pcF+4 when not taken).
- validE  in  1  execute slot holds a real instruction (0 = bubble).
- branchE  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved (treated as none).
- jumpE  in  2  00 none, 01 JAL, 10 JALR, 11 reserved (none).
- zeroE  in  1  ALU rs1==rs2.
- ltE  in  1  signed rs1<rs2.
- ltuE  in  1  unsigned rs1<rs2.
- pcE  in  XLEN  PC of the execute instruction.
- targetE  in  XLEN  pcE+imm (branch/JAL target).
- jalrTargetE  in  XLEN  (rs1+imm)&~1.
- predTakenE, predTargetE  in  1, XLEN  fetch prediction piped to execute.
- redirectE  out  1  mispredict: flush IF/ID and load redirectPCE.
- redirectPCE  out  XLEN  correct next PC.
- brCount, missCount  out  PERF_W each  resolved control-flow count / mispredict count.

Behaviour:
- Reset (async, immediate on rst high):
  - all counters = weakly-not-taken (01 for CTR_W=2, i.e. 2**(CTR_W-1)-1);
  - BTB valid bits = 0; perf counters = 0;
  - redirectE = 0 (combinational outputs follow the cleared state).
- Fetch lookup is combinational from registered tables, zero latency.
  - hit = valid[idx] && tag[idx]==pcF[XLEN-1:IDX_W+2].
  - predTakenF = hit && ctr[idx][MSB].
  - predTargetF = predTakenF ? btbTarget[idx] : pcF+4.
- Execute resolution (combinational):
  - actualTaken by type: BEQ zeroE; BNE !zeroE; BLT ltE; BGE !ltE; BLTU ltuE; BGEU !ltuE; JAL 1; JALR 1; none 0.
  - actualTarget = JALR ? jalrTargetE : targetE.
  - If both branchE≠000 and jumpE≠00: jumpE wins.
- redirectE = validE && ((actualTaken != predTakenE) || (actualTaken && predTargetE != actualTarget)).
  - redirectPCE = actualTaken ? actualTarget : pcE+4.
  - Bubbles (validE=0) never redirect; redirectPCE is don't-care (drive pcE+4).
- Training, on clk edge when validE and instruction is a conditional branch or JAL:
  - counter saturates up if taken, down if not (no wrap at all-ones / zero);
  - on taken: write tag, target, valid=1;
  - on not-taken: leave BTB entry untouched.
  - JALR never trains (target is data-dependent).
- Same-cycle fetch read and execute write to one index: fetch sees the pre-update value (no bypass). The write is visible from the next cycle.
- Perf counters:
  - brCount increments on each validE with a control-flow type;
  - missCount increments when redirectE=1;
  - both saturate at all-ones.
- Reset mid-operation: tables and counters clear immediately. No partial writes survive.

Optional Feature:
- Macro BPU_GSHARE_EN.
- Defined:
  - adds an IDX_W-bit global history register, reset 0, shifted left with actualTaken on every training update;
  - BHT index = pc[IDX_W+1:2] XOR GHR, for both lookup and update;
  - update uses the GHR value that was current at lookup, so ghrE must be piped alongside predTakenE;
  - adds ports ghrF out IDX_W and ghrE in IDX_W.
  - BTB indexing stays PC-only.
- Undefined: pure bimodal PC indexing, no GHR and no extra ports.

Decomposition:
- Package bpu_pkg holds:
  - branch type constants (BR_NONE..BR_BGEU);
  - jump constants (J_NONE, J_JAL, J_JALR);
  - counter init/threshold constants;
  - a function computing actualTaken from type and flags.
- Sub-module sat_counter_table: the BHT array with read port, update port, saturate logic, and async reset init.
- BTB and perf counters stay in the top module.

Test Plan:
- Reset, then pcF=0x40 -> predTakenF=0, predTargetF=0x44, brCount=0, missCount=0.
- Same BEQ at pcE=0x40, zeroE=1, targetE=0x80, predTakenE=0, resolved 2 times:
  - first -> redirectE=1, redirectPCE=0x80, counter 01→10;
  - then pcF=0x40 -> predTakenF=1, predTargetF=0x80;
  - second resolve with predTakenE=1, predTargetE=0x80 -> redirectE=0, counter 10→11.
- BNE with zeroE=1 predicted taken -> redirectE=1, redirectPCE=pcE+4. Counter saturates at 00 after 3 more not-taken; a fourth decrement stays at 00.
- BLT vs BLTU with ltE=1, ltuE=0 -> BLT taken and BLTU not taken; BGE/BGEU give the inverse.
- JALR with jalrTargetE=0x1234, predTakenE=0 -> redirectE=1, redirectPCE=0x1234, no table write. validE=0 with branchE=BEQ -> no redirect and no counter change.
- Assert rst while a training update is pending -> all entries back to weakly-not-taken and perf counters 0. Drive missCount to all-ones -> it stays all-ones.
